// File: rtl/tsconf_uart_pkg.sv
// Shared types and constants for the tsconf UART_TX pin arbiter.
// Source indices match bit positions in the one-hot grant vector {uart,midi,tape}.
package tsconf_uart_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int unsigned NUM_SRC = 3;

    localparam logic [1:0] SRC_TAPE = 2'd0;
    localparam logic [1:0] SRC_MIDI = 2'd1;
    localparam logic [1:0] SRC_UART = 2'd2;

    // Highest priority first.
    localparam logic [1:0] PRIO_ORDER [NUM_SRC] = '{SRC_UART, SRC_MIDI, SRC_TAPE};

    function automatic logic [NUM_SRC-1:0] prio_pick(input logic [NUM_SRC-1:0] req);
        logic [NUM_SRC-1:0] pick;
        pick = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pick == '0 && req[PRIO_ORDER[2'(i)]]) begin
                pick[PRIO_ORDER[2'(i)]] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_edge_det.sv
// Per-source history register and toggle detector.
// The history resets to the idle level so a source resting elsewhere shows one edge.
module uart_tx_edge_det #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    output logic edge_o
);

    logic src_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= IDLE_LEVEL;
        end else begin
            src_q <= src_i;
        end
    end

    assign edge_o = src_i ^ src_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Ownership arbiter for the shared UART_TX pin: first toggling source claims it,
// holds it until idle for HOLD_CYCLES, and non-owner toggles are flagged as collisions.
module uart_tx_arbiter
    import tsconf_uart_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1680000,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       tape_in,
    input  logic       midi_in,
    input  logic       uart_in,
    input  logic       collision_clr,
    output logic       tx_out,
    output logic [2:0] grant,
    output logic       collision
);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("uart_tx_arbiter: HOLD_CYCLES must be >= 2");
    end

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] winner;
    logic               owner_edge;
    logic               other_edge;
    logic               owner_lvl;
    logic               collision_set;
    logic               collision_d;

    arb_state_t         state_q;
    logic [NUM_SRC-1:0] grant_q;
    logic               tx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               collision_q;

    assign src = {uart_in, midi_in, tape_in};

    uart_tx_edge_det #(.IDLE_LEVEL(IDLE_LEVEL)) u_edge_tape (
        .clk_i (clk_sys),
        .rst_ni(rst_n),
        .src_i (src[SRC_TAPE]),
        .edge_o(edges[SRC_TAPE])
    );

    uart_tx_edge_det #(.IDLE_LEVEL(IDLE_LEVEL)) u_edge_midi (
        .clk_i (clk_sys),
        .rst_ni(rst_n),
        .src_i (src[SRC_MIDI]),
        .edge_o(edges[SRC_MIDI])
    );

    uart_tx_edge_det #(.IDLE_LEVEL(IDLE_LEVEL)) u_edge_uart (
        .clk_i (clk_sys),
        .rst_ni(rst_n),
        .src_i (src[SRC_UART]),
        .edge_o(edges[SRC_UART])
    );

    always_comb begin
        winner     = prio_pick(edges);
        owner_edge = |(edges & grant_q);
        other_edge = |(edges & ~grant_q);
        owner_lvl  = |(src & grant_q);

        // Losers of a simultaneous claim count as collisions, as do intruders on an owned pin.
        collision_set = 1'b0;
        if (state_q == FREE && (edges & ~winner) != '0) begin
            collision_set = 1'b1;
        end
        if (state_q == OWNED && other_edge) begin
            collision_set = 1'b1;
        end
        collision_d = collision_set | (collision_q & ~collision_clr);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FREE;
            grant_q     <= '0;
            tx_q        <= IDLE_LEVEL;
            cnt_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
            case (state_q)
                FREE: begin
                    tx_q <= IDLE_LEVEL;
                    if (edges != '0) begin
                        grant_q <= winner;
                        tx_q    <= |(src & winner);
                        cnt_q   <= CNT_RELOAD;
                        state_q <= OWNED;
                    end
                end
                OWNED: begin
                    tx_q <= owner_lvl;
                    if (owner_edge) begin
                        cnt_q <= CNT_RELOAD;
                    end else if (cnt_q == '0) begin
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    tx_q    <= IDLE_LEVEL;
                    grant_q <= '0;
                    state_q <= FREE;
                end
                default: begin
                    state_q <= FREE;
                end
            endcase
        end
    end

    assign tx_out    = tx_q;
    assign grant     = grant_q;
    assign collision = collision_q;

endmodule
